// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the PWM duty-ramp block.
//   - default widths and prescaler rate
//   - ramp FSM state encoding
package pwm_duty_ramp_pkg;

   localparam int unsigned DUTY_W_DEF   = 7;
   localparam int unsigned STEP_W_DEF   = 4;
   localparam int unsigned RATE_DIV_DEF = 10416;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_RAMP_DOWN = 2'd2
   } ramp_state_e;

endpackage : pwm_duty_ramp_pkg

// File: rtl/pwm_duty_ramp_rate_prescaler.sv
// Step-rate prescaler: counts 0..RATE_DIV-1 while enabled and flags the last count.
// Ports:
//   clk     system clock
//   rst_n   synchronous reset, active-high (1 = reset)
//   en      count enable
//   clr     synchronous clear to 0 (wins over en)
//   tick_c  combinational: en && count at its last value
module rate_prescaler #(
   parameter int unsigned RATE_DIV = 10416
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick_c
);

   localparam int unsigned CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);

   logic [CNT_W-1:0] count_q;

   assign tick_c = en && (count_q == CNT_LAST);

   // Counter wraps to 0 on the tick cycle so ticks are exactly RATE_DIV apart.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         if (tick_c) count_q <= '0;
         else        count_q <= count_q + CNT_W'(1);
      end
   end

endmodule : rate_prescaler

// File: rtl/pwm_duty_ramp.sv
// Duty-word slew limiter feeding the PWM comparator.
// Moves duty_o toward a commanded target in fixed steps, one step every
// RATE_DIV clocks, clamping the last step so the target is never passed.
// Ports:
//   clk       system clock
//   rst_n     synchronous reset, active-high (1 = reset) despite the name
//   target_i  commanded final duty, sampled with load_i
//   step_i    increment per step, sampled with load_i (0 behaves as 1)
//   load_i    command strobe, accepted in any state
//   abort_i   freeze duty_o and return to idle
//   duty_o    registered duty word
//   busy_o    ramp in progress
//   done_o    one-cycle pulse when duty_o reaches target
//   dir_o     1 while ramping up
module pwm_duty_ramp
   import pwm_duty_ramp_pkg::*;
#(
   parameter int unsigned DUTY_W   = DUTY_W_DEF,
   parameter int unsigned STEP_W   = STEP_W_DEF,
   parameter int unsigned RATE_DIV = RATE_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DUTY_W-1:0] target_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              load_i,
   input  logic              abort_i,
   output logic [DUTY_W-1:0] duty_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              dir_o
);

   // One guard bit so gap/sum never wrap.
   localparam int unsigned CALC_W = DUTY_W + 1;

   ramp_state_e       state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] target_q, target_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              dir_q, dir_d;

   logic              pre_en;
   logic              pre_clr;
   logic              tick;
   logic [CALC_W-1:0] gap;
   logic [CALC_W-1:0] step_ext;

   // Prescaler only runs while ramping; phase survives a retarget.
   assign pre_en = (state_q != ST_IDLE);

   rate_prescaler #(
      .RATE_DIV (RATE_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (pre_en),
      .clr    (pre_clr),
      .tick_c (tick)
   );

   // Next-state, datapath and output decode.
   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      step_d   = step_q;
      done_d   = 1'b0;
      pre_clr  = 1'b0;
      step_ext = CALC_W'(step_q);
      gap      = '0;

      if (state_q == ST_RAMP_UP) begin
         gap = CALC_W'(target_q) - CALC_W'(duty_q);
      end else if (state_q == ST_RAMP_DOWN) begin
         gap = CALC_W'(duty_q) - CALC_W'(target_q);
      end

      if (abort_i) begin
         state_d = ST_IDLE;
         pre_clr = 1'b1;
      end else if (load_i) begin
         // A tick in this cycle is deliberately ignored.
         target_d = target_i;
         step_d   = (step_i == '0) ? STEP_W'(1) : step_i;
         if (state_q == ST_IDLE) pre_clr = 1'b1;
         if (target_i > duty_q) begin
            state_d = ST_RAMP_UP;
         end else if (target_i < duty_q) begin
            state_d = ST_RAMP_DOWN;
         end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end else if (tick) begin
         unique case (state_q)
            ST_RAMP_UP: begin
               if (gap <= step_ext) begin
                  duty_d  = target_q;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  duty_d = DUTY_W'(CALC_W'(duty_q) + step_ext);
               end
            end
            ST_RAMP_DOWN: begin
               if (gap <= step_ext) begin
                  duty_d  = target_q;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  duty_d = DUTY_W'(CALC_W'(duty_q) - step_ext);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
      dir_d  = (state_d == ST_RAMP_UP);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q  <= ST_IDLE;
         duty_q   <= '0;
         target_q <= '0;
         step_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         dir_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         step_q   <= step_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         dir_q    <= dir_d;
      end
   end

   assign duty_o = duty_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign dir_o  = dir_q;

endmodule : pwm_duty_ramp

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp (RATE_DIV = 4).
// Commands expand into a timeline of expected output events; a monitor pops
// one event whenever duty_o changes or done_o pulses.
module tb_pwm_duty_ramp;

   localparam int unsigned DUTY_W   = 7;
   localparam int unsigned STEP_W   = 4;
   localparam int          RATE_DIV = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [DUTY_W-1:0] target_i = '0;
   logic [STEP_W-1:0] step_i = '0;
   logic              load_i = 1'b0;
   logic              abort_i = 1'b0;
   logic [DUTY_W-1:0] duty_o;
   logic              busy_o;
   logic              done_o;
   logic              dir_o;

   pwm_duty_ramp #(
      .DUTY_W   (DUTY_W),
      .STEP_W   (STEP_W),
      .RATE_DIV (RATE_DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .target_i (target_i),
      .step_i   (step_i),
      .load_i   (load_i),
      .abort_i  (abort_i),
      .duty_o   (duty_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .dir_o    (dir_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int duty;
      bit done;
      bit busy;
      bit dir;
   } ev_t;

   ev_t sb[$];
   ev_t plan[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   bit  mon_en = 1'b0;
   int  m_base = 0;
   int  m_origin = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: any duty change or done pulse is one output event.
   initial begin
      logic [DUTY_W-1:0] prev;
      ev_t e;
      prev = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && (duty_o !== prev || done_o === 1'b1)) begin
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
               n_bad = n_bad + 1;
               $display("FAIL unexpected_event @cyc %0d: duty=%0d done=%0b busy=%0b dir=%0b",
                        cyc, duty_o, done_o, busy_o, dir_o);
            end else begin
               e = sb.pop_front();
               if (e.cyc != cyc || duty_o !== DUTY_W'(e.duty) || done_o !== e.done ||
                   busy_o !== e.busy || dir_o !== e.dir) begin
                  n_bad = n_bad + 1;
                  $display("FAIL event: got cyc=%0d duty=%0d done=%0b busy=%0b dir=%0b expected cyc=%0d duty=%0d done=%0b busy=%0b dir=%0b",
                           cyc, duty_o, done_o, busy_o, dir_o, e.cyc, e.duty, e.done, e.busy, e.dir);
               end
            end
         end
         prev = duty_o;
      end
   end

   // Model: duty value in force just before edge L.
   function automatic int duty_before(input int l);
      int v;
      v = m_base;
      foreach (plan[i]) if (plan[i].cyc < l) v = plan[i].duty;
      return v;
   endfunction

   function automatic bit idle_at(input int l);
      foreach (plan[i]) if (plan[i].cyc >= l) return 1'b0;
      return 1'b1;
   endfunction

   // Forget every planned event from edge L onward.
   task automatic truncate(input int l);
      m_base = duty_before(l);
      plan.delete();
      while (sb.size() != 0 && sb[$].cyc >= l) void'(sb.pop_back());
   endtask

   task automatic push_ev(input int c, input int d, input bit dn, input bit bz, input bit dr);
      ev_t e;
      e = '{cyc: c, duty: d, done: dn, busy: bz, dir: dr};
      sb.push_back(e);
      plan.push_back(e);
   endtask

   task automatic cmd_load(input int tgt, input int stp);
      int  l, d, s, t;
      bit  was_idle, up;
      l = cyc + 1;
      was_idle = idle_at(l);
      d = duty_before(l);
      truncate(l);
      if (was_idle) m_origin = l;
      s = (stp == 0) ? 1 : stp;
      t = m_origin + RATE_DIV * ((l - m_origin) / RATE_DIV + 1);
      up = (tgt > d);
      if (d == tgt) begin
         push_ev(l, d, 1'b1, 1'b0, 1'b0);
      end else begin
         while (d != tgt) begin
            if ((up ? tgt - d : d - tgt) <= s) begin
               d = tgt;
               push_ev(t, d, 1'b1, 1'b0, 1'b0);
            end else begin
               d = up ? d + s : d - s;
               push_ev(t, d, 1'b0, 1'b1, up);
            end
            t = t + RATE_DIV;
         end
      end
      target_i = DUTY_W'(tgt);
      step_i   = STEP_W'(stp);
      load_i   = 1'b1;
      @(negedge clk);
      load_i   = 1'b0;
   endtask

   task automatic cmd_abort();
      int d;
      d = duty_before(cyc + 1);
      truncate(cyc + 1);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_busy", int'(busy_o), 0);
      check("abort_done", int'(done_o), 0);
      check("abort_duty", int'(duty_o), d);
   endtask

   task automatic cmd_reset(input int n);
      int l;
      l = cyc + 1;
      truncate(l);
      if (m_base != 0) sb.push_back('{cyc: l, duty: 0, done: 1'b0, busy: 1'b0, dir: 1'b0});
      m_base = 0;
      rst_n = 1'b1;
      repeat (n) @(negedge clk);
      rst_n = 1'b0;
      check("rst_duty", int'(duty_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_done", int'(done_o), 0);
      check("rst_dir",  int'(dir_o),  0);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n = n + 1;
      end
      if (sb.size() != 0) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL drain_timeout: got %0d pending events expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int l, r;
      @(negedge clk);
      cmd_reset(3);
      mon_en = 1'b1;

      // Soft-start 0 -> 20 in steps of 5.
      cmd_load(20, 5);
      wait_idle(200);
      check("idle_busy", int'(busy_o), 0);

      // Ramp down with clamped final step.
      cmd_load(3, 8);
      check("down_dir", int'(dir_o), 0);
      check("down_busy", int'(busy_o), 1);
      wait_idle(200);

      // Load equal to current duty.
      cmd_load(3, 2);
      check("eq_done", int'(done_o), 1);
      check("eq_busy", int'(busy_o), 0);
      check("eq_duty", int'(duty_o), 3);
      wait_idle(50);

      // Step 0 acts as 1; abort at duty 9.
      cmd_reset(1);
      l = cyc + 1;
      cmd_load(127, 0);
      check("up_dir", int'(dir_o), 1);
      wait_until(l + 9 * RATE_DIV + 1);
      cmd_abort();
      repeat (12) @(negedge clk);
      check("abort_hold", int'(duty_o), 9);
      wait_idle(50);

      // Retarget down at duty 40 keeps prescaler phase.
      cmd_reset(1);
      l = cyc + 1;
      cmd_load(100, 4);
      wait_until(l + 10 * RATE_DIV + 2);
      cmd_load(30, 3);
      check("retgt_dir", int'(dir_o), 0);
      wait_idle(300);

      // Reset mid-ramp at duty 50, then load coinciding with a tick.
      cmd_reset(1);
      l = cyc + 1;
      cmd_load(100, 5);
      wait_until(l + 10 * RATE_DIV + 1);
      cmd_reset(1);
      l = cyc + 1;
      cmd_load(60, 5);
      wait_until(l + RATE_DIV - 1);
      cmd_load(60, 5);
      wait_idle(300);

      // Random commands.
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60) begin
            cmd_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 40)) @(negedge clk);
         end else if (r < 70) begin
            cmd_abort();
         end else if (r < 73) begin
            cmd_reset(int'($urandom_range(1, 3)));
         end else begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
         end
      end
      wait_idle(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pwm_duty_ramp
